// File: rtl/test_port_sniffer.sv
// rtl/test_port_sniffer.sv - test-port store sniffer: dedup, byte swap, session framing, word FIFO
// Optional build macro: SNIFFER_DEDUP_EN (collapse stall-repeated stores into one event)
module test_port_sniffer #(
  parameter logic [29:0] TEST_PORT    = 30'hFF,
  parameter logic [31:0] BEGIN_SYMBOL = 32'h00000168,
  parameter logic [31:0] END_SYMBOL   = 32'hFFFFFD5D,
  parameter int          DEPTH_LOG2   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_wen,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        active,
  output logic        done,
  output logic        overflow,
  output logic [7:0]  word_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic        w_qual;
  logic        w_armed;
  logic        w_event;
  logic [31:0] w_swapped;
  logic        w_is_begin;
  logic        w_is_end;
  logic        w_push;

  logic [DEPTH_LOG2:0] r_wr_ptr;
  logic [DEPTH_LOG2:0] r_rd_ptr;
  logic [31:0]         r_mem_data [DEPTH];
  logic                r_mem_last [DEPTH];
  logic                r_overflow;
  logic [7:0]          r_count;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_accept;

  assign w_qual     = mem_wen && (mem_addr == TEST_PORT);
  assign w_swapped  = {mem_wdata[7:0], mem_wdata[15:8], mem_wdata[23:16], mem_wdata[31:24]};
  assign w_is_begin = (w_swapped == BEGIN_SYMBOL);
  assign w_is_end   = (w_swapped == END_SYMBOL);

`ifdef SNIFFER_DEDUP_EN
  // A store held through a D-cache stall fires only on its first cycle;
  // any write cycle disarms, any idle cycle re-arms.
  logic r_armed;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_armed <= 1'b1;
    end else begin
      r_armed <= !mem_wen;
    end
  end

  assign w_armed = r_armed;
`else
  assign w_armed = 1'b1;
`endif

  assign w_event = w_qual && w_armed;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_event && w_is_begin) begin
          w_state_nxt = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (w_event) begin
          w_push = 1'b1;
          if (w_is_end) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_DONE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]) &&
                    (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]);
  assign w_pop    = !w_empty && out_ready;
  // A pop in the same cycle frees the slot, so a push on full still lands.
  assign w_accept = w_push && (!w_full || w_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_last[i] <= 1'b0;
      end
    end else if (w_accept) begin
      r_mem_data[r_wr_ptr[DEPTH_LOG2-1:0]] <= w_swapped;
      r_mem_last[r_wr_ptr[DEPTH_LOG2-1:0]] <= w_is_end;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + (DEPTH_LOG2+1)'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + (DEPTH_LOG2+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow <= 1'b0;
      r_count    <= 8'd0;
    end else begin
      if (w_push && !w_accept) begin
        r_overflow <= 1'b1;
      end
      if (w_accept && (r_count != 8'hFF)) begin
        r_count <= r_count + 8'd1;
      end
    end
  end

  assign out_valid  = !w_empty;
  assign out_data   = r_mem_data[r_rd_ptr[DEPTH_LOG2-1:0]];
  assign out_last   = r_mem_last[r_rd_ptr[DEPTH_LOG2-1:0]];
  assign active     = (r_state == S_ACTIVE);
  assign done       = (r_state == S_DONE);
  assign overflow   = r_overflow;
  assign word_count = r_count;

endmodule

// File: tb/tb_test_port_sniffer.sv
// tb/tb_test_port_sniffer.sv - scoreboard bench for test_port_sniffer
module tb_test_port_sniffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wen;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        active;
  logic        done;
  logic        overflow;
  logic [7:0]  word_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [32:0] exp_q [$];

  always #5 clk = ~clk;

  test_port_sniffer dut (
    .clk        (clk),
    .rst        (rst),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wen    (mem_wen),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .active     (active),
    .done       (done),
    .overflow   (overflow),
    .word_count (word_count)
  );

  // Each word the DUT hands over (valid && ready, sampled mid-cycle) is checked against the queue head.
  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_word got data=%h last=%b required none", out_data, out_last);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        if ({out_last, out_data} !== e) begin
          n_err++;
          $display("FAIL stream_word got last=%b data=%h required last=%b data=%h",
                   out_last, out_data, e[32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [29:0] a, input logic [31:0] d, input int n);
    mem_addr  = a;
    mem_wdata = d;
    mem_wen   = 1'b1;
    repeat (n) step();
    mem_wen = 1'b0;
    step();
  endtask

  task automatic expect_word(input logic [31:0] d, input logic last);
    exp_q.push_back({last, d});
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    mem_wen   = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) step();
    step();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain got %0d words pending required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wen   = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    n_cmp += 7;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b required 0", out_valid); end
    if (out_data !== 32'h0) begin n_err++; $display("FAIL reset_data got %h required 0", out_data); end
    if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_last got %b required 0", out_last); end
    if (active !== 1'b0) begin n_err++; $display("FAIL reset_active got %b required 0", active); end
    if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b required 0", done); end
    if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %b required 0", overflow); end
    if (word_count !== 8'd0) begin n_err++; $display("FAIL reset_count got %0d required 0", word_count); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_begin();
    store(30'hFF, 32'h68010000, 1);
    n_cmp += 3;
    if (active !== 1'b1) begin n_err++; $display("FAIL begin_active got %b required 1", active); end
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL begin_valid got %b required 0", out_valid); end
    if (word_count !== 8'd0) begin n_err++; $display("FAIL begin_count got %0d required 0", word_count); end
  endtask

  task automatic test_dedup();
    int exp_n;
`ifdef SNIFFER_DEDUP_EN
    exp_n = 1;
`else
    exp_n = 3;
`endif
    out_ready = 1'b1;
    for (int i = 0; i < exp_n; i++) expect_word(32'h00000001, 1'b0);
    store(30'hFF, 32'h01000000, 3);
    drain("dedup");
    n_cmp++;
    if (word_count !== 8'(exp_n)) begin
      n_err++; $display("FAIL dedup_count got %0d required %0d", word_count, exp_n);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    store(30'hFF, 32'h68010000, 1);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) expect_word({24'h0, 8'hA0 + 8'(i)}, 1'b0);
      store(30'hFF, {8'hA0 + 8'(i), 24'h0}, 1);
    end
    n_cmp += 3;
    if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b required 1", overflow); end
    if (word_count !== 8'd4) begin n_err++; $display("FAIL ovf_count got %0d required 4", word_count); end
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL ovf_valid got %b required 1", out_valid); end
    out_ready = 1'b1;
    drain("ovf");
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL ovf_empty got %b required 0", out_valid); end
  endtask

  task automatic test_full_pop_and_end();
    do_reset();
    store(30'hFF, 32'h68010000, 1);
    for (int i = 0; i < 4; i++) begin
      expect_word({24'h0, 8'hC0 + 8'(i)}, 1'b0);
      store(30'hFF, {8'hC0 + 8'(i), 24'h0}, 1);
    end
    expect_word(32'h00000168, 1'b0);
    out_ready = 1'b1;
    store(30'hFF, 32'h68010000, 1);
    drain("fullpop");
    n_cmp += 3;
    if (overflow !== 1'b0) begin n_err++; $display("FAIL fullpop_ovf got %b required 0", overflow); end
    if (word_count !== 8'd5) begin n_err++; $display("FAIL fullpop_count got %0d required 5", word_count); end
    if (active !== 1'b1) begin n_err++; $display("FAIL fullpop_active got %b required 1", active); end

    store(30'hFE, 32'h05000000, 1);
    step();
    n_cmp += 2;
    if (word_count !== 8'd5) begin n_err++; $display("FAIL addr_filter_count got %0d required 5", word_count); end
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL addr_filter_valid got %b required 0", out_valid); end

    expect_word(32'hFFFFFD5D, 1'b1);
    store(30'hFF, 32'h5DFDFFFF, 1);
    n_cmp += 2;
    if (done !== 1'b1) begin n_err++; $display("FAIL end_done got %b required 1", done); end
    if (active !== 1'b0) begin n_err++; $display("FAIL end_active got %b required 0", active); end
    drain("end");
    store(30'hFF, 32'h01000000, 1);
    store(30'hFF, 32'h68010000, 1);
    step();
    n_cmp += 3;
    if (word_count !== 8'd6) begin n_err++; $display("FAIL done_count got %0d required 6", word_count); end
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL done_valid got %b required 0", out_valid); end
    if (done !== 1'b1) begin n_err++; $display("FAIL done_hold got %b required 1", done); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    store(30'hFF, 32'h68010000, 1);
    store(30'hFF, 32'h11000000, 1);
    store(30'hFF, 32'h22000000, 1);
    n_cmp++;
    if (word_count !== 8'd2) begin n_err++; $display("FAIL mid_pre_count got %0d required 2", word_count); end
    #2;
    rst = 1'b0;
    #1;
    n_cmp += 6;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid got %b required 0", out_valid); end
    if (out_data !== 32'h0) begin n_err++; $display("FAIL mid_data got %h required 0", out_data); end
    if (active !== 1'b0) begin n_err++; $display("FAIL mid_active got %b required 0", active); end
    if (done !== 1'b0) begin n_err++; $display("FAIL mid_done got %b required 0", done); end
    if (overflow !== 1'b0) begin n_err++; $display("FAIL mid_ovf got %b required 0", overflow); end
    if (word_count !== 8'd0) begin n_err++; $display("FAIL mid_count got %0d required 0", word_count); end
    exp_q.delete();
    step();
    step();
    rst = 1'b1;
    out_ready = 1'b1;
    step();
    store(30'hFF, 32'h02000000, 1);
    step();
    n_cmp += 3;
    if (active !== 1'b0) begin n_err++; $display("FAIL idle_active got %b required 0", active); end
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL idle_valid got %b required 0", out_valid); end
    if (word_count !== 8'd0) begin n_err++; $display("FAIL idle_count got %0d required 0", word_count); end
  endtask

  initial begin
    test_reset();
    test_begin();
    test_dedup();
    test_overflow();
    test_full_pop_and_end();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
